rf_access_sequencer: RTL
========================

# rf_access_sequencer

Initiator-side controller for the 32×8 dual-read / single-write register file. It accepts one register-to-register command at a time over a valid/ready handshake and drives the register file's read addresses. It captures both operands, computes an 8-bit ALU result, writes it back through the write port, and reports completion. It sits between the instruction decode logic and the register file and is the only agent that drives the register file's address, data and write-mode inputs.

## Interface
- ADDR_W, 5, register address width (32 entries)
- DATA_W, 8, register data width
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR
- cmd_rd / cmd_rs1 / cmd_rs2  input  ADDR_W each  destination and source registers
- read_add_1 / read_add_2  output  ADDR_W each  register-file read addresses (rs1, rs2)
- read_out_1 / read_out_2  input  DATA_W each  register-file read data; combinational from the addresses
- write_add  output  ADDR_W  register-file write address
- write_inp  output  DATA_W  register-file write data
- mode  output  1  register-file write enable; 1 for exactly one cycle per command
- done  output  1  one-cycle completion pulse
- result  output  DATA_W  ALU result; valid while done=1 and held until the next result

## Operation
- FSM states: IDLE → READ → EXEC → WRITE → DONE → IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch op, rd, rs1 and rs2, then go to READ.
  - While cmd_ready=0, cmd_valid is ignored. No command is queued.
- READ:
  - read_add_1=rs1 and read_add_2=rs2 (registered outputs).
  - At the end of the cycle, capture read_out_1 and read_out_2 into the operand registers a and b.
- EXEC:
  - res = op(a, b) computed modulo 2^8.
  - SUB is a − b two's-complement wrap: 0x00−0x01 = 0xFF. ADD wraps: 0xFF+0x01 = 0x00.
  - No carry or borrow output.
- WRITE: mode=1, write_add=rd, write_inp=res for this one cycle.
- DONE: done=1, result=res. Next state is IDLE.
- rd equal to rs1 or rs2 is legal. Operands are captured in READ, before the write-back.
- Reset values (all outputs and state):
  - State IDLE.
  - read_add_1, read_add_2, write_add, write_inp, result all 0.
  - mode=0, done=0.
  - cmd_ready=0 during the reset cycle and 1 from the first cycle after rst deasserts.
- Reset mid-operation: on the next edge the FSM is in IDLE and mode=0.
  - No write is issued for the aborted command.
  - done is not pulsed.
  - result returns to 0.

## Timing
- Accept at edge N (state becomes READ).
  - Operands captured at edge N+1.
  - mode=1 during cycle N+3.
  - done=1 during cycle N+4.
  - cmd_ready=1 again in cycle N+5.
- Throughput: one command per 5 cycles.
- A command presented in cycle N+5 is accepted at the edge ending that cycle.
- All outputs are registered, except cmd_ready, which decodes the current state (IDLE && !rst).
- The register file write takes effect at the edge ending the WRITE cycle. A following command reading rd therefore sees the new value.

## Configuration
- RF_SEQ_ZERO_REG_EN:
  - Defined: register 0 is hardwired zero.
    - A source operand whose address is 0 is captured as 0x00, regardless of read_out_x.
    - A command with rd=0 still sequences through WRITE with mode=0. No write is issued, and done/result behave normally.
  - Undefined: register 0 is an ordinary register, read and written like any other.

## Structure
- Package rf_seq_pkg holds:
  - ADDR_W and DATA_W constants.
  - Op encoding enum (OP_ADD, OP_SUB, OP_AND, OP_OR).
  - FSM state enum.
- One combinational sub-module, rf_seq_alu: inputs op, a, b; output res [DATA_W-1:0]. It holds the four operations only.
- The FSM, operand/command registers and output registers live in rf_access_sequencer.

## Test plan
- Reset, then idle: outputs all 0, mode=0, done=0; cmd_ready=1 from the first post-reset cycle. Verified for 10 idle cycles with no register-file write.
- ADD with r7=0x23, r11=0x39, rd=6: read_add_1=11 and read_add_2=7 in READ; mode=1, write_add=6, write_inp=0x5C at N+3; done=1, result=0x5C at N+4.
- Wrap cases:
  - SUB with a=0x00, b=0x01 → result 0xFF.
  - ADD with a=0xFF, b=0x01 → result 0x00.
  - AND 0xCC & 0x0F → 0x0C.
  - OR 0xCC | 0x03 → 0xCF.
- Back-to-back with cmd_valid held high:
  - Commands accepted exactly 5 cycles apart; cmd_valid during busy cycles is ignored.
  - A second command with rs1 = first command's rd reads the freshly written value.
- rst asserted during EXEC: next cycle state is IDLE, mode never pulses, done never pulses, and the target register is unchanged.
- With RF_SEQ_ZERO_REG_EN:
  - ADD rd=0, rs1=0, rs2=5 (r5=0x11) → result 0x11, mode stays 0.
  - Without the macro: an r0 preset to 0x40 gives result 0x51, and r0 is written with 0x51.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// rtl/rf_seq_pkg.sv - widths, op encoding and FSM states for the register-file access sequencer
package rf_seq_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rf_access_sequencer_if.sv
// rtl/rf_access_sequencer_if.sv - command handshake plus register-file port bundle
interface rf_access_sequencer_if;
  import rf_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] read_add_1;
  logic [ADDR_W-1:0] read_add_2;
  logic [DATA_W-1:0] read_out_1;
  logic [DATA_W-1:0] read_out_2;
  logic [ADDR_W-1:0] write_add;
  logic [DATA_W-1:0] write_inp;
  logic              mode;
  logic              done;
  logic [DATA_W-1:0] result;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, read_out_1, read_out_2,
    output cmd_ready, read_add_1, read_add_2, write_add, write_inp, mode, done, result
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, read_out_1, read_out_2,
    input  cmd_ready, read_add_1, read_add_2, write_add, write_inp, mode, done, result
  );

endinterface

// File: rtl/rf_seq_alu.sv
// rtl/rf_seq_alu.sv - combinational 8-bit ALU, results wrap modulo 2^DATA_W
module rf_seq_alu
  import rf_seq_pkg::*;
(
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res
);

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/rf_access_sequencer.sv
// rtl/rf_access_sequencer.sv - IDLE/READ/EXEC/WRITE/DONE register-file sequencer; RF_SEQ_ZERO_REG_EN hardwires r0 to zero
module rf_access_sequencer
  import rf_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  rf_access_sequencer_if.slave bus
);

  state_e            state;
  op_e               op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] read_add_1_q;
  logic [ADDR_W-1:0] read_add_2_q;
  logic [ADDR_W-1:0] write_add_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] write_inp_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] opnd_1;
  logic [DATA_W-1:0] opnd_2;
  logic              mode_q;
  logic              done_q;
  logic              write_en;

`ifdef RF_SEQ_ZERO_REG_EN
  // r0 reads as zero and is never written; the command still walks through WRITE
  assign opnd_1   = (read_add_1_q == '0) ? '0 : bus.read_out_1;
  assign opnd_2   = (read_add_2_q == '0) ? '0 : bus.read_out_2;
  assign write_en = (rd_q != '0);
`else
  assign opnd_1   = bus.read_out_1;
  assign opnd_2   = bus.read_out_2;
  assign write_en = 1'b1;
`endif

  rf_seq_alu u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_q         <= OP_ADD;
      rd_q         <= '0;
      read_add_1_q <= '0;
      read_add_2_q <= '0;
      write_add_q  <= '0;
      a_q          <= '0;
      b_q          <= '0;
      write_inp_q  <= '0;
      result_q     <= '0;
      mode_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_q         <= op_e'(bus.cmd_op);
            rd_q         <= bus.cmd_rd;
            read_add_1_q <= bus.cmd_rs1;
            read_add_2_q <= bus.cmd_rs2;
            state        <= ST_READ;
          end
        end
        ST_READ: begin
          a_q   <= opnd_1;
          b_q   <= opnd_2;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          mode_q      <= write_en;
          write_add_q <= rd_q;
          write_inp_q <= alu_res;
          state       <= ST_WRITE;
        end
        ST_WRITE: begin
          mode_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= write_inp_q;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == ST_IDLE) && !rst;
  assign bus.read_add_1 = read_add_1_q;
  assign bus.read_add_2 = read_add_2_q;
  assign bus.write_add  = write_add_q;
  assign bus.write_inp  = write_inp_q;
  assign bus.mode       = mode_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;

endmodule
